// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates the single register-file write port between the ALU pipe (A)
// and the load/store pipe (B). It drives the register file from a registered
// output stage and keeps a per-register pending-write scoreboard that the
// issue stage uses to stall on RAW/WAW hazards.
//
// Optional build macro: RR_ARB_EN
//   defined   : round-robin between A and B when both are valid
//   undefined : fixed priority, B (load/store) wins when both are valid
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_rd,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_W-1:0]    b_rd,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 issue_ready,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 RegWEn,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t          last_grant;
    grant_t          last_grant_next;
    logic            grant_a;
    logic            grant_b;
    logic [NREG-1:0] busy_next;

    // Last-grant state register; B after reset so A wins the first contest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Grant decision and last-grant next state; nothing is granted in reset.
    always_comb begin
        grant_a         = 1'b0;
        grant_b         = 1'b0;
        last_grant_next = last_grant;
        if (rst_n) begin
            if (a_valid && b_valid) begin
`ifdef RR_ARB_EN
                if (last_grant == GRANT_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
`else
                grant_b = 1'b1;
`endif
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
            if (grant_a) begin
                last_grant_next = GRANT_A;
            end else if (grant_b) begin
                last_grant_next = GRANT_B;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Output stage: capture the granted request; x0 writes are accepted but
    // never enabled, and address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWEn  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (grant_a) begin
            RegWEn  <= (a_rd != '0);
            rd_addr <= a_rd;
            rd_data <= a_data;
        end else if (grant_b) begin
            RegWEn  <= (b_rd != '0);
            rd_addr <= b_rd;
            rd_data <= b_data;
        end else begin
            RegWEn  <= 1'b0;
        end
    end

    // Scoreboard next state: clear on the register-file write, then set on
    // issue so a same-cycle set wins; x0 is never tracked.
    always_comb begin
        busy_next = busy;
        if (RegWEn) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign issue_ready = !busy[issue_rd];

endmodule
